// File: rtl/pipelined_seg_adder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipelined_seg_adder: WIDTH-bit add/sub, one SEG_WIDTH carry segment/stage.  |
// | Optional ovf output: define PIPELINED_SEG_ADDER_OVERFLOW_EN.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipelined_seg_adder #(
  parameter int WIDTH     = 143,
  parameter int SEG_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   sum,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPELINED_SEG_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSEG = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;

  logic w_adv;

  // Stage k holds operands with segments 0..k-1 already resolved into st_s.
  logic             st_v [NSEG+1];
  logic [WIDTH-1:0] st_a [NSEG+1];
  logic [WIDTH-1:0] st_b [NSEG+1];
  logic [WIDTH-1:0] st_s [NSEG+1];
  logic             st_c [NSEG+1];

  logic             v0_q;
  logic [WIDTH-1:0] a0_q;
  logic [WIDTH-1:0] b0_q;
  logic             c0_q;

  logic [WIDTH:0]   sum_q;
  logic             out_valid_q;

  assign in_ready  = ~(out_valid_q & ~out_ready);
  assign w_adv     = in_ready;
  assign sum       = sum_q;
  assign out_valid = out_valid_q;

  // Subtraction is folded in up front: invert B and force the carry-in to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      a0_q <= '0;
      b0_q <= '0;
      c0_q <= 1'b0;
    end else if (w_adv) begin
      v0_q <= in_valid;
      if (in_valid) begin
        a0_q <= a;
        b0_q <= sub ? ~b : b;
        c0_q <= sub | cin;
      end
    end
  end

  assign st_v[0] = v0_q;
  assign st_a[0] = a0_q;
  assign st_b[0] = b0_q;
  assign st_s[0] = '0;
  assign st_c[0] = c0_q;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int LO = k * SEG_WIDTH;
    localparam int SW = (k == NSEG - 1) ? (WIDTH - LO) : SEG_WIDTH;

    logic [SW:0]      w_seg_sum;
    logic [WIDTH-1:0] s_d;
    logic             v_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;

    assign w_seg_sum = {1'b0, st_a[k][LO +: SW]} + {1'b0, st_b[k][LO +: SW]}
                     + {{SW{1'b0}}, st_c[k]};

    always_comb begin
      s_d            = st_s[k];
      s_d[LO +: SW]  = w_seg_sum[SW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (w_adv) begin
        v_q <= st_v[k];
        if (st_v[k]) begin
          a_q <= st_a[k];
          b_q <= st_b[k];
          s_q <= s_d;
          c_q <= w_seg_sum[SW];
        end
      end
    end

    assign st_v[k+1] = v_q;
    assign st_a[k+1] = a_q;
    assign st_b[k+1] = b_q;
    assign st_s[k+1] = s_q;
    assign st_c[k+1] = c_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
    end else if (w_adv) begin
      out_valid_q <= st_v[NSEG];
      if (st_v[NSEG]) begin
        sum_q <= {st_c[NSEG], st_s[NSEG]};
      end
    end
  end

`ifdef PIPELINED_SEG_ADDER_OVERFLOW_EN
  logic ovf_q;

  // Carry into the MSB is recovered as a ^ b ^ s at that bit position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (w_adv && st_v[NSEG]) begin
      ovf_q <= st_c[NSEG] ^ st_a[NSEG][WIDTH-1] ^ st_b[NSEG][WIDTH-1]
             ^ st_s[NSEG][WIDTH-1];
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
`default_nettype wire
